// File: rtl/imem_pkg.sv
// Shared definitions for the instruction store: controller states, the NOP
// word and the bytes-per-word helper used to turn a byte PC into a word index.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // NOP is all zeros; wide enough for any supported DATA_W, sliced at use.
  localparam logic [255:0] NOP = '0;

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-port instruction RAM: synchronous write, synchronous read.
// The read register only updates on a read, so it naturally holds the last
// fetched word through stalls and idle cycles.
module imem_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Array write port; no reset so it maps onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  // Registered read data, cleared by reset so the fetched word reads 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_store.sv
// Instruction store: clears memory to NOP after reset, accepts a program
// stream in LOAD, then serves one-cycle-latency fetches in RUN.
// Optional feature macro IMEM_FAULT_EN: flags misaligned or out-of-range
// fetches (returning NOP) instead of ignoring low bits and wrapping the index.
//
// Load handshake: a word transfers on every rising edge where load_valid and
// load_ready are both 1; load_ready is 1 exactly while in LOAD, and
// load_valid is ignored in any other state.
module instr_store
  import imem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              reprogram,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] pc,
  input  logic              stall,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              fault,
  output logic              busy,
  output state_e            o_dbg_state
);

  localparam int BPW   = bytes_per_word(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] BPW_A    = ADDR_W'(BPW);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0]  ONE_IDX  = IDX_W'(1);
  localparam logic [DATA_W-1:0] NOP_W    = NOP[DATA_W-1:0];

  state_e            r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic              r_valid;
  logic              r_fault;
  logic              r_load_ready;
  logic              r_busy;

  logic [ADDR_W-1:0] w_word;
  logic [IDX_W-1:0]  w_idx;
  logic              w_bad;
  logic              w_fetch;
  logic              w_we;
  logic              w_re;
  logic [IDX_W-1:0]  w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata;

  assign w_word = pc / BPW_A;
  assign w_idx  = IDX_W'(w_word % DEPTH_A);

`ifdef IMEM_FAULT_EN
  assign w_bad = ((pc % BPW_A) != '0) || (w_word >= DEPTH_A);
`else
  assign w_bad = 1'b0;
`endif

  // reprogram takes priority: a fetch in the same cycle is dropped.
  assign w_fetch = (r_state == ST_RUN) && fetch_en && !stall && !reprogram;
  assign w_re    = w_fetch && !w_bad;
  assign w_we    = (r_state == ST_CLEAR) || ((r_state == ST_LOAD) && load_valid);
  assign w_wdata = (r_state == ST_CLEAR) ? NOP_W : load_data;
  assign w_addr  = (r_state == ST_RUN) ? w_idx : r_ptr;

  imem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  // Controller FSM: CLEAR sweep, LOAD stream, RUN fetch bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_CLEAR;
      r_ptr        <= '0;
      r_valid      <= 1'b0;
      r_fault      <= 1'b0;
      r_load_ready <= 1'b0;
      r_busy       <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_valid <= 1'b0;
          if (r_ptr == LAST_IDX) begin
            r_state      <= ST_LOAD;
            r_ptr        <= '0;
            r_load_ready <= 1'b1;
          end else begin
            r_ptr <= r_ptr + ONE_IDX;
          end
        end
        ST_LOAD: begin
          r_valid <= 1'b0;
          if (load_valid) begin
            if (load_last || (r_ptr == LAST_IDX)) begin
              r_state      <= ST_RUN;
              r_ptr        <= '0;
              r_load_ready <= 1'b0;
              r_busy       <= 1'b0;
            end else begin
              r_ptr <= r_ptr + ONE_IDX;
            end
          end
        end
        ST_RUN: begin
          if (reprogram) begin
            r_state      <= ST_LOAD;
            r_ptr        <= '0;
            r_valid      <= 1'b0;
            r_load_ready <= 1'b1;
            r_busy       <= 1'b1;
          end else if (!stall) begin
            r_valid <= fetch_en;
            if (fetch_en) r_fault <= w_bad;
          end
        end
        default: begin
          r_state      <= ST_CLEAR;
          r_ptr        <= '0;
          r_valid      <= 1'b0;
          r_load_ready <= 1'b0;
          r_busy       <= 1'b1;
        end
      endcase
    end
  end

  // A faulted fetch skips the RAM read, so the NOP substitution lives here.
  assign instr       = r_fault ? NOP_W : w_rdata;
  assign instr_valid = r_valid;
  assign fault       = r_fault && r_valid;
  assign load_ready  = r_load_ready;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_instr_store.sv
// Directed, table-driven bench for instr_store (DATA_W=16, DEPTH=64).
module tb_instr_store;
  import imem_pkg::*;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 16;

  logic              clk;
  logic              rst;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              reprogram;
  logic              fetch_en;
  logic [ADDR_W-1:0] pc;
  logic              stall;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              fault;
  logic              busy;
  state_e            dbg_state;

  int n_checks;
  int n_errors;

  instr_store #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .reprogram   (reprogram),
    .fetch_en    (fetch_en),
    .pc          (pc),
    .stall       (stall),
    .instr       (instr),
    .instr_valid (instr_valid),
    .fault       (fault),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic              fe;
    logic              st;
    logic [DATA_W-1:0] e_instr;
    logic              e_valid;
    logic              e_fault;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sample just after the edge, away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expect exactly DEPTH cycles of CLEAR from the current (post-release) point.
  task automatic wait_clear();
    for (int i = 0; i < DEPTH; i++) begin
      chk("clear_ready", 32'(load_ready), 32'd0);
      chk("clear_busy", 32'(busy), 32'd1);
      step();
    end
    chk("clear_done_ready", 32'(load_ready), 32'd1);
  endtask

  task automatic load_word(input logic [DATA_W-1:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic fetch(input string name, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    pc       = a;
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    chk(name, 32'(instr), 32'(exp));
    chk({name, "_valid"}, 32'(instr_valid), 32'd1);
  endtask

  task automatic pulse_reprogram();
    reprogram = 1'b1;
    step();
    reprogram = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    reprogram  = 1'b0;
    fetch_en   = 1'b0;
    pc         = '0;
    stall      = 1'b0;

    vecs[0]  = '{16'd0,   1'b1, 1'b0, 16'h1010, 1'b1, 1'b0};
    vecs[1]  = '{16'd2,   1'b1, 1'b0, 16'h1011, 1'b1, 1'b0};
    vecs[2]  = '{16'd4,   1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[3]  = '{16'd2,   1'b1, 1'b0, 16'h1011, 1'b1, 1'b0};
    vecs[4]  = '{16'd0,   1'b1, 1'b1, 16'h1011, 1'b1, 1'b0};
    vecs[5]  = '{16'd0,   1'b1, 1'b1, 16'h1011, 1'b1, 1'b0};
    vecs[6]  = '{16'd0,   1'b1, 1'b1, 16'h1011, 1'b1, 1'b0};
    vecs[7]  = '{16'd0,   1'b0, 1'b0, 16'h1011, 1'b0, 1'b0};
    vecs[8]  = '{16'd0,   1'b1, 1'b0, 16'h1010, 1'b1, 1'b0};
`ifdef IMEM_FAULT_EN
    vecs[9]  = '{16'd3,   1'b1, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[10] = '{16'd128, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1};
`else
    vecs[9]  = '{16'd3,   1'b1, 1'b0, 16'h1011, 1'b1, 1'b0};
    vecs[10] = '{16'd128, 1'b1, 1'b0, 16'h1010, 1'b1, 1'b0};
`endif
    vecs[11] = '{16'd126, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[12] = '{16'd2,   1'b1, 1'b0, 16'h1011, 1'b1, 1'b0};

    // Reset state
    #2;
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ready", 32'(load_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_clear();
    chk("state_load", 32'(dbg_state), 32'(ST_LOAD));

    // Initial program
    load_word(16'h1010, 1'b0);
    chk("load1_busy", 32'(busy), 32'd1);
    load_word(16'h1011, 1'b1);
    chk("run_busy", 32'(busy), 32'd0);
    chk("run_ready", 32'(load_ready), 32'd0);
    chk("state_run", 32'(dbg_state), 32'(ST_RUN));
    chk("run_valid0", 32'(instr_valid), 32'd0);

    // Table of fetch/stall vectors
    for (int i = 0; i < NVEC; i++) begin
      pc       = vecs[i].pc;
      fetch_en = vecs[i].fe;
      stall    = vecs[i].st;
      step();
      chk($sformatf("vec%0d_instr", i), 32'(instr), 32'(vecs[i].e_instr));
      chk($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d_fault", i), 32'(fault), 32'(vecs[i].e_fault));
    end
    fetch_en = 1'b0;
    stall    = 1'b0;

    // Reprogram with a concurrent fetch: fetch is dropped, LOAD entered
    pc       = 16'd0;
    fetch_en = 1'b1;
    pulse_reprogram();
    chk("reprog_valid", 32'(instr_valid), 32'd0);
    chk("reprog_busy", 32'(busy), 32'd1);
    chk("reprog_ready", 32'(load_ready), 32'd1);
    load_word(16'h9412, 1'b1);
    chk("reload_valid", 32'(instr_valid), 32'd0);
    fetch_en = 1'b0;
    step();
    fetch("reprog_pc0", 16'd0, 16'h9412);
    fetch("reprog_pc2", 16'd2, 16'h1011);

    // Full-depth load with no last flag ends on the final index
    pulse_reprogram();
    for (int i = 0; i < DEPTH; i++) begin
      load_word(16'hA000 + 16'(i), 1'b0);
      if (i == DEPTH - 2) chk("full_busy_62", 32'(busy), 32'd1);
    end
    chk("full_busy_done", 32'(busy), 32'd0);
    chk("full_ready_done", 32'(load_ready), 32'd0);
    fetch("full_pc126", 16'd126, 16'hA03F);
    fetch("full_pc0", 16'd0, 16'hA000);

    // Reset in the middle of LOAD discards everything
    pulse_reprogram();
    load_word(16'h5555, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_instr", 32'(instr), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_ready", 32'(load_ready), 32'd0);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_clear();
    load_word(16'h0000, 1'b1);
    chk("post_busy", 32'(busy), 32'd0);
    fetch("post_pc2", 16'd2, 16'h0000);
    fetch("post_pc0", 16'd0, 16'h0000);
    fetch("post_pc126", 16'd126, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
